// File: rtl/systolic_output_deskew_pkg.sv
// Shared definitions for the systolic output deskew block: FSM state
// encoding, the default column-slice width and the per-column delay depth.
package systolic_output_deskew_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_ERR  = 2'd2
   } deskew_state_e;

   // Width of one column result slice (matches the MAU accumulator width).
   localparam int unsigned DESKEW_SLICE_W = 32;

   // Column j arrives j cycles late, so it needs cols-1-j stages to line up
   // with the last column, which arrives unregistered.
   function automatic int unsigned deskew_depth(input int unsigned cols,
                                                input int unsigned col);
      return cols - 1 - col;
   endfunction

endpackage

// File: rtl/systolic_output_deskew_row_fifo.sv
// Show-ahead FIFO holding aligned result rows. Head entry is visible on
// rdata_o whenever empty_o is low. A push while full is accepted only when a
// pop happens in the same cycle; a pop while empty is ignored.
module deskew_row_fifo #(
   parameter int unsigned WIDTH = 128,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = 1;
   localparam logic [AW:0]   CNT_ONE = 1;
   localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q, count_d;
   logic             push_ok, pop_ok;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_FULL);
   assign pop_ok  = pop_i & ~empty_o;
   assign push_ok = push_i & (~full_o | pop_ok);
   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Occupancy changes only when exactly one of push/pop takes effect.
   always_comb begin
      count_d = count_q;
      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Storage, pointers (wrap modulo DEPTH) and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= wr_ptr_q + PTR_ONE;
         end
         if (pop_ok) rd_ptr_q <= rd_ptr_q + PTR_ONE;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/systolic_output_deskew.sv
// Removes the diagonal skew from the bottom row of the MAU array, buffers
// aligned rows in a show-ahead FIFO, counts rows per tile and flags skew and
// overflow errors.
// Build option: define DESKEW_RELU_EN to clamp negative fields to zero
// before they enter the FIFO.
module systolic_output_deskew
   import systolic_output_deskew_pkg::*;
#(
   parameter int unsigned COLS          = 4,
   parameter int unsigned ACC_LENGTH    = DESKEW_SLICE_W,
   parameter int unsigned FIFO_DEPTH    = 8,
   parameter int unsigned ROWS_PER_TILE = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [COLS*ACC_LENGTH-1:0]     col_acc,
   input  logic [COLS-1:0]                col_valid,
   input  logic                           out_ready,
   output logic [COLS*ACC_LENGTH-1:0]     out_data,
   output logic                           out_valid,
   output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
   output logic                           tile_done,
   output logic                           skew_err,
   output logic                           ovf_err,
   input  logic                           clr_err
);

   localparam int unsigned RW = $clog2(ROWS_PER_TILE) + 1;
   localparam logic [RW-1:0] ROW_LAST = RW'(ROWS_PER_TILE - 1);
   localparam logic [RW-1:0] ROW_ONE  = 1;
   localparam logic [$clog2(FIFO_DEPTH):0] FIFO_ONE = 1;

   logic [COLS*ACC_LENGTH-1:0] dly_row, wr_row;
   logic [COLS-1:0]            dly_vld;

   // Per-column delay lines: data and valid travel together.
   for (genvar j = 0; j < COLS; j++) begin : g_col
      localparam int unsigned D = deskew_depth(COLS, j);
      if (D == 0) begin : g_pass
         assign dly_row[j*ACC_LENGTH +: ACC_LENGTH] = col_acc[j*ACC_LENGTH +: ACC_LENGTH];
         assign dly_vld[j] = col_valid[j];
      end else begin : g_dly
         logic [ACC_LENGTH-1:0] acc_q [D];
         logic [D-1:0]          vld_q;
         // Shift column j right by D cycles.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int unsigned k = 0; k < D; k++) acc_q[k] <= '0;
               vld_q <= '0;
            end else begin
               acc_q[0] <= col_acc[j*ACC_LENGTH +: ACC_LENGTH];
               vld_q[0] <= col_valid[j];
               for (int unsigned k = 1; k < D; k++) begin
                  acc_q[k] <= acc_q[k-1];
                  vld_q[k] <= vld_q[k-1];
               end
            end
         end
         assign dly_row[j*ACC_LENGTH +: ACC_LENGTH] = acc_q[D-1];
         assign dly_vld[j] = vld_q[D-1];
      end
   end

   // Row written into the FIFO, optionally with negative fields clamped.
   always_comb begin
      wr_row = dly_row;
`ifdef DESKEW_RELU_EN
      for (int unsigned j = 0; j < COLS; j++) begin
         if (dly_row[j*ACC_LENGTH + ACC_LENGTH - 1]) wr_row[j*ACC_LENGTH +: ACC_LENGTH] = '0;
      end
`endif
   end

   logic push_req, skew_ev, ovf_ev, pop, push_acc;
   logic fifo_full, fifo_empty, fifo_empty_next, tile_last;

   assign push_req  = &dly_vld;
   assign skew_ev   = (|dly_vld) & ~push_req;
   assign pop       = ~fifo_empty & out_ready;
   assign push_acc  = push_req & (~fifo_full | pop);
   assign ovf_ev    = push_req & fifo_full & ~pop;
   assign out_valid = ~fifo_empty;

   deskew_row_fifo #(
      .WIDTH (COLS*ACC_LENGTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push_req),
      .wdata_i (wr_row),
      .pop_i   (pop),
      .rdata_o (out_data),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   logic skew_q, skew_d, ovf_q, ovf_d;

   // Sticky errors: a new event in the clearing cycle keeps the flag set.
   always_comb begin
      skew_d = skew_ev | (skew_q & ~clr_err);
      ovf_d  = ovf_ev  | (ovf_q  & ~clr_err);
   end

   // Sticky error registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skew_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         skew_q <= skew_d;
         ovf_q  <= ovf_d;
      end
   end

   assign skew_err = skew_q;
   assign ovf_err  = ovf_q;

   deskew_state_e   state_q, state_d;
   logic [RW-1:0]   row_cnt_q, row_cnt_d;
   logic            tile_done_q, tile_done_d;

   assign tile_last       = pop & (row_cnt_q == ROW_LAST);
   // A pop leaves the FIFO empty only if it held one row and nothing arrives.
   assign fifo_empty_next = (fifo_count == FIFO_ONE) & ~push_acc;

   // Tile FSM: row counting in RUN, error parking in ERR.
   always_comb begin
      state_d     = state_q;
      row_cnt_d   = row_cnt_q;
      tile_done_d = 1'b0;
      unique case (state_q)
         ST_IDLE: if (push_acc) state_d = ST_RUN;
         ST_RUN: begin
            if (pop) row_cnt_d = tile_last ? '0 : row_cnt_q + ROW_ONE;
            tile_done_d = tile_last;
            if (skew_ev | ovf_ev | skew_q | ovf_q) state_d = ST_ERR;
            else if (tile_last && fifo_empty_next) state_d = ST_IDLE;
         end
         ST_ERR: begin
            if (clr_err) begin
               state_d   = ST_IDLE;
               row_cnt_d = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM state, row counter and tile_done pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         row_cnt_q   <= '0;
         tile_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_cnt_q   <= row_cnt_d;
         tile_done_q <= tile_done_d;
      end
   end

   assign tile_done = tile_done_q;

endmodule

// File: tb/tb_systolic_output_deskew.sv
// Self-checking bench for systolic_output_deskew with a row-level reference
// model: rows are launched with per-column masks, a row lands in the model
// FIFO COLS-1 cycles after its column-0 result, and the model applies the
// handshake, error and tile rules directly.
module tb_systolic_output_deskew;

   localparam int unsigned COLS  = 4;
   localparam int unsigned W     = 32;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned RPT   = 4;
   localparam int unsigned CW    = $clog2(DEPTH) + 1;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [COLS*W-1:0]   col_acc = '0;
   logic [COLS-1:0]     col_valid = '0;
   logic                out_ready = 1'b0;
   logic                clr_err = 1'b0;
   logic [COLS*W-1:0]   out_data;
   logic                out_valid;
   logic [CW-1:0]       fifo_count;
   logic                tile_done, skew_err, ovf_err;

   systolic_output_deskew #(
      .COLS          (COLS),
      .ACC_LENGTH    (W),
      .FIFO_DEPTH    (DEPTH),
      .ROWS_PER_TILE (RPT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .col_acc    (col_acc),
      .col_valid  (col_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .fifo_count (fifo_count),
      .tile_done  (tile_done),
      .skew_err   (skew_err),
      .ovf_err    (ovf_err),
      .clr_err    (clr_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [COLS*W-1:0] d;
      logic [COLS-1:0]   m;
      int                start;
   } row_t;

   row_t              infl[$];
   logic [COLS*W-1:0] mq[$];
   int  now;
   int  errors = 0;
   int  checks = 0;
   int  m_state, m_cnt;
   bit  m_skew, m_ovf, m_tile;

   function automatic logic [COLS*W-1:0] expect_row(input logic [COLS*W-1:0] d);
      logic [COLS*W-1:0] r;
      r = d;
`ifdef DESKEW_RELU_EN
      for (int j = 0; j < COLS; j++) if (d[j*W+W-1]) r[j*W +: W] = '0;
`endif
      return r;
   endfunction

   function automatic logic [COLS*W-1:0] rand_row();
      logic [COLS*W-1:0] r;
      for (int j = 0; j < COLS; j++) r[j*W +: W] = $urandom;
      return r;
   endfunction

   task automatic model_reset();
      infl.delete();
      mq.delete();
      m_state = 0; m_cnt = 0; m_skew = 0; m_ovf = 0; m_tile = 0;
      now = 0;
   endtask

   task automatic launch(input logic [COLS*W-1:0] d, input logic [COLS-1:0] m);
      row_t r;
      r.d = d; r.m = m; r.start = now;
      infl.push_back(r);
   endtask

   // One clock cycle: drive skewed columns, advance the model at the edge.
   task automatic cycle();
      logic [COLS*W-1:0] aligned;
      bit push_req, skew_ev, pop, accept, ovf_ev, last;
      int sz_after;
      aligned = '0; push_req = 0; skew_ev = 0;
      for (int j = 0; j < COLS; j++) begin
         col_acc[j*W +: W] = $urandom;
         col_valid[j] = 1'b0;
      end
      foreach (infl[i]) begin
         for (int j = 0; j < COLS; j++) begin
            if (infl[i].start + j == now) begin
               col_acc[j*W +: W] = infl[i].d[j*W +: W];
               col_valid[j] = infl[i].m[j];
            end
         end
         if (infl[i].start + int'(COLS) - 1 == now) begin
            if (&infl[i].m) begin
               push_req = 1;
               aligned = expect_row(infl[i].d);
            end else if (|infl[i].m) skew_ev = 1;
         end
      end
      pop      = (mq.size() != 0) && out_ready;
      accept   = push_req && ((mq.size() < int'(DEPTH)) || pop);
      ovf_ev   = push_req && !accept;
      last     = (m_state == 1) && pop && (m_cnt == int'(RPT) - 1);
      sz_after = mq.size() - int'(pop) + int'(accept);
      @(posedge clk);
      m_tile = last;
      case (m_state)
         0: if (accept) m_state = 1;
         1: begin
            if (pop) m_cnt = last ? 0 : m_cnt + 1;
            if (skew_ev || ovf_ev || m_skew || m_ovf) m_state = 2;
            else if (last && sz_after == 0) m_state = 0;
         end
         default: if (clr_err) begin m_state = 0; m_cnt = 0; end
      endcase
      m_skew = skew_ev || (m_skew && !clr_err);
      m_ovf  = ovf_ev  || (m_ovf  && !clr_err);
      if (pop) void'(mq.pop_front());
      if (accept) mq.push_back(aligned);
      while (infl.size() > 0 && infl[0].start + int'(COLS) - 1 <= now) void'(infl.pop_front());
      #1;
      now++;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      col_valid = '0;
      out_ready = 1'b0;
      clr_err = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      checks++; if (fifo_count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", out_data); end
      checks++; if ({tile_done, skew_err, ovf_err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {tile_done, skew_err, ovf_err}); end
      checks++; if (int'(dut.state_q) !== 0) begin errors++; $display("FAIL reset_state: got %0d want 0", int'(dut.state_q)); end
      do_reset();
   endtask

   task automatic test_single_row();
      logic [COLS*W-1:0] r;
      logic [COLS*W-1:0] want;
      do_reset();
      for (int j = 0; j < COLS; j++) r[j*W +: W] = W'(10 + j);
      want = 128'h0000000d_0000000c_0000000b_0000000a;
      launch(r, '1);
      for (int k = 0; k < 6; k++) begin
         cycle();
         checks++; if (out_valid !== (k >= 3)) begin errors++; $display("FAIL single_latency: cycle t+%0d got %b want %b", k + 1, out_valid, k >= 3); end
      end
      checks++; if (out_data !== want) begin errors++; $display("FAIL single_data: got %h want %h", out_data, want); end
      out_ready = 1'b1;
      cycle();
      checks++; if (fifo_count !== '0) begin errors++; $display("FAIL single_pop: count %0d want 0", fifo_count); end
   endtask

   task automatic test_back_to_back();
      int seen = 0;
      do_reset();
      out_ready = 1'b1;
      for (int k = 0; k < 14; k++) begin
         if (k < 6) launch(rand_row(), '1);
         cycle();
         if (out_valid) seen++;
         checks++; if (fifo_count > 1) begin errors++; $display("FAIL b2b_count: got %0d want <=1", fifo_count); end
         checks++; if (out_valid !== (mq.size() != 0)) begin errors++; $display("FAIL b2b_valid: got %b want %b", out_valid, mq.size() != 0); end
         if (mq.size() != 0) begin
            checks++; if (out_data !== mq[0]) begin errors++; $display("FAIL b2b_data: got %h want %h", out_data, mq[0]); end
         end
         checks++; if (skew_err !== 1'b0) begin errors++; $display("FAIL b2b_skew: got %b want 0", skew_err); end
      end
      checks++; if (seen !== 6) begin errors++; $display("FAIL b2b_rows: got %0d want 6", seen); end
   endtask

   task automatic test_overflow();
      int seen = 0;
      do_reset();
      out_ready = 1'b0;
      for (int k = 0; k < 14; k++) begin
         if (k < 9) launch(rand_row(), '1);
         cycle();
      end
      checks++; if (fifo_count !== CW'(8)) begin errors++; $display("FAIL ovf_count: got %0d want 8", fifo_count); end
      checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", ovf_err); end
      checks++; if (int'(dut.state_q) !== 2) begin errors++; $display("FAIL ovf_state: got %0d want 2", int'(dut.state_q)); end
      clr_err = 1'b1;
      cycle();
      clr_err = 1'b0;
      checks++; if (int'(dut.state_q) !== 0) begin errors++; $display("FAIL ovf_clr_state: got %0d want 0", int'(dut.state_q)); end
      checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_clr_flag: got %b want 0", ovf_err); end
      out_ready = 1'b1;
      for (int k = 0; k < 11; k++) begin
         if (out_valid) begin
            seen++;
            checks++; if (out_data !== mq[0]) begin errors++; $display("FAIL ovf_drain_data: got %h want %h", out_data, mq[0]); end
         end
         cycle();
      end
      checks++; if (seen !== 8) begin errors++; $display("FAIL ovf_drain_rows: got %0d want 8", seen); end
   endtask

   task automatic test_skew_err();
      int seen = 0;
      do_reset();
      out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         if (k < 3) launch(rand_row(), (k == 1) ? 4'b1011 : 4'b1111);
         cycle();
         if (out_valid) begin
            seen++;
            checks++; if (out_data !== mq[0]) begin errors++; $display("FAIL skew_data: got %h want %h", out_data, mq[0]); end
         end
      end
      checks++; if (seen !== 2) begin errors++; $display("FAIL skew_rows: got %0d want 2", seen); end
      checks++; if (skew_err !== 1'b1) begin errors++; $display("FAIL skew_flag: got %b want 1", skew_err); end
      checks++; if (int'(dut.state_q) !== 2) begin errors++; $display("FAIL skew_state: got %0d want 2", int'(dut.state_q)); end
   endtask

   task automatic test_tile_done();
      int pulses = 0;
      do_reset();
      out_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         if (k < 4) launch(rand_row(), '1);
         cycle();
         if (tile_done) pulses++;
         checks++; if (tile_done !== m_tile) begin errors++; $display("FAIL tile_pulse: cycle %0d got %b want %b", now, tile_done, m_tile); end
      end
      checks++; if (pulses !== 1) begin errors++; $display("FAIL tile_count: got %0d want 1", pulses); end
      checks++; if (int'(dut.state_q) !== 0) begin errors++; $display("FAIL tile_state: got %0d want 0", int'(dut.state_q)); end
   endtask

   task automatic test_reset_mid_tile();
      do_reset();
      out_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (k < 3 || k == 4) launch(rand_row(), '1);
         cycle();
      end
      checks++; if (fifo_count !== CW'(3)) begin errors++; $display("FAIL mid_buffered: got %0d want 3", fifo_count); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", out_valid); end
      checks++; if (fifo_count !== '0) begin errors++; $display("FAIL mid_count: got %0d want 0", fifo_count); end
      checks++; if ({skew_err, ovf_err} !== 2'b00) begin errors++; $display("FAIL mid_errs: got %b want 00", {skew_err, ovf_err}); end
      do_reset();
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         cycle();
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale: got %b want 0", out_valid); end
      end
   endtask

   task automatic test_relu();
      logic [COLS*W-1:0] r;
      logic [W-1:0] want0;
      do_reset();
      r = rand_row();
      r[W-1:0] = 32'hFFFF_FFFB;
      for (int j = 1; j < COLS; j++) r[j*W +: W] = W'(j);
`ifdef DESKEW_RELU_EN
      want0 = '0;
`else
      want0 = 32'hFFFF_FFFB;
`endif
      launch(r, '1);
      repeat (5) cycle();
      checks++; if (out_data[W-1:0] !== want0) begin errors++; $display("FAIL relu_neg: got %h want %h", out_data[W-1:0], want0); end
      checks++; if (out_data[COLS*W-1:W] !== r[COLS*W-1:W]) begin errors++; $display("FAIL relu_pos: got %h want %h", out_data[COLS*W-1:W], r[COLS*W-1:W]); end
   endtask

   task automatic test_random();
      logic [COLS-1:0] mk;
      do_reset();
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 1) == 1) begin
            mk = '1;
            if ($urandom_range(0, 9) == 0) mk[$urandom_range(0, COLS-1)] = 1'b0;
            launch(expect_row(rand_row()) ^ rand_row(), mk);
         end
         out_ready = (k % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         clr_err = ($urandom_range(0, 15) == 0);
         cycle();
         checks++; if (out_valid !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_valid: got %b want %b", out_valid, mq.size() != 0); end
         checks++; if (fifo_count !== CW'(mq.size())) begin errors++; $display("FAIL rnd_count: got %0d want %0d", fifo_count, mq.size()); end
         if (mq.size() != 0) begin
            checks++; if (out_data !== mq[0]) begin errors++; $display("FAIL rnd_data: got %h want %h", out_data, mq[0]); end
         end
         checks++; if ({tile_done, skew_err, ovf_err} !== {m_tile, m_skew, m_ovf}) begin errors++; $display("FAIL rnd_flags: got %b want %b", {tile_done, skew_err, ovf_err}, {m_tile, m_skew, m_ovf}); end
         checks++; if (int'(dut.state_q) !== m_state) begin errors++; $display("FAIL rnd_state: got %0d want %0d", int'(dut.state_q), m_state); end
      end
      clr_err = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single_row();
      test_back_to_back();
      test_overflow();
      test_skew_err();
      test_tile_done();
      test_reset_mid_tile();
      test_relu();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
